// File: rtl/imm_ext_pipe.sv
// rtl/imm_ext_pipe.sv - pipelined immediate extension unit with 2-entry output buffer
//
// Purpose:
//    Extends an IN_W-bit immediate to OUT_W bits in one of four modes and queues
//    the result in a 2-entry FIFO with valid/ready handshakes on both sides, so the
//    producer and consumer stages can stall independently.
//
// Optional feature macro: IMM_EXT_CNT_EN
//    Defined   - neg_cnt counts accepted negative sign-mode (01/10) immediates,
//                saturating at 16'hFFFF, cleared only by rst.
//    Undefined - no counter logic; neg_cnt is tied to 16'h0000.
//
// Ports:
//    clk        in   1      clock, rising edge
//    rst        in   1      synchronous active-high reset
//    flush      in   1      synchronous clear of buffered results (below rst)
//    in_valid   in   1      imm_in/mode valid
//    in_ready   out  1      unit can accept an input
//    imm_in     in   IN_W   raw immediate field
//    mode       in   2      00 zero, 01 sign, 10 sign<<SHIFT, 11 upper-placed
//    out_valid  out  1      out_data holds a result
//    out_ready  in   1      consumer takes out_data
//    out_data   out  OUT_W  extended immediate at buffer head
//    neg_cnt    out  16     negative sign-mode push count

module imm_ext_pipe #(
   parameter int IN_W  = 14,
   parameter int OUT_W = 32,
   parameter int SHIFT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  imm_in,
   input  logic [1:0]       mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [15:0]      neg_cnt
);

   localparam int PAD_W = OUT_W - IN_W;

   logic [OUT_W-1:0] mem_q [2];
   logic [1:0]       count_q, count_d;
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;

   logic [OUT_W-1:0] ext_res;
   logic [OUT_W-1:0] sign_ext;
   logic             push;
   logic             pop;

   // Combinational extension of the incoming immediate.
   always_comb begin
      sign_ext = {{PAD_W{imm_in[IN_W-1]}}, imm_in};
      ext_res  = '0;
      unique case (mode)
         2'b00:   ext_res = {{PAD_W{1'b0}}, imm_in};
         2'b01:   ext_res = sign_ext;
         // Sign extension happens before the shift so the top bits stay sign copies.
         2'b10:   ext_res = sign_ext << SHIFT;
         default: ext_res = {imm_in, {PAD_W{1'b0}}};
      endcase
   end

   // Handshake status comes only from registered occupancy.
   assign in_ready  = (count_q != 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign out_data  = mem_q[rd_ptr_q];

   assign push = in_valid & in_ready;
   assign pop  = out_valid & out_ready;

   always_comb begin
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         wr_ptr_d = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q  <= 2'd0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         mem_q[0] <= '0;
         mem_q[1] <= '0;
      end else if (flush) begin
         // Entries keep stale contents; they are unreachable once count is 0.
         count_q  <= 2'd0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
      end else begin
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         if (push) begin
            mem_q[wr_ptr_q] <= ext_res;
         end
      end
   end

`ifdef IMM_EXT_CNT_EN
   logic [15:0] neg_cnt_q;
   logic        neg_hit;

   // A negative sign-mode push still counts even if a same-cycle flush discards it.
   assign neg_hit = push & (mode == 2'b01 || mode == 2'b10) & imm_in[IN_W-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         neg_cnt_q <= 16'h0000;
      end else if (neg_hit && neg_cnt_q != 16'hFFFF) begin
         neg_cnt_q <= neg_cnt_q + 16'h0001;
      end
   end

   assign neg_cnt = neg_cnt_q;
`else
   assign neg_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb/tb_imm_ext_pipe.sv - directed self-checking bench for imm_ext_pipe

module tb_imm_ext_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [13:0] imm_in;
   logic [1:0]  mode;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [15:0] neg_cnt;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

`ifdef IMM_EXT_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   imm_ext_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .imm_in    (imm_in),
      .mode      (mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .neg_cnt   (neg_cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   logic [31:0] exp_neg_a [4] = '{32'h0000_3FF6, 32'hFFFF_FFF6, 32'hFFFF_FFD8, 32'hFFD8_0000};
   logic [31:0] exp_pos   [4] = '{32'h0000_000A, 32'h0000_000A, 32'h0000_0028, 32'h0028_0000};

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; imm_in = '0; mode = 2'b00; out_ready = 1'b0;
      step();
      step();
      rst = 1'b0;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data",  out_data, 32'd0);
      chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);
      chk("rst_neg_cnt",   {16'd0, neg_cnt}, 32'd0);

      // Negative immediate in every mode, consumer always ready.
      out_ready = 1'b1;
      for (int m = 0; m < 4; m++) begin
         in_valid = 1'b1; imm_in = 14'h3FF6; mode = 2'(m);
         step();
         chk($sformatf("neg_m%0d_data", m), out_data, exp_neg_a[m]);
         chk($sformatf("neg_m%0d_valid", m), {31'd0, out_valid}, 32'd1);
         chk($sformatf("neg_m%0d_in_ready", m), {31'd0, in_ready}, 32'd1);
      end
      in_valid = 1'b0;
      step();
      chk("neg_drain_valid", {31'd0, out_valid}, 32'd0);
      chk("neg_cnt_after_neg", {16'd0, neg_cnt}, CNT_EN ? 32'd2 : 32'd0);

      // Positive immediate in every mode.
      for (int m = 0; m < 4; m++) begin
         in_valid = 1'b1; imm_in = 14'h000A; mode = 2'(m);
         step();
         chk($sformatf("pos_m%0d_data", m), out_data, exp_pos[m]);
      end
      in_valid = 1'b0;
      step();
      chk("pos_drain_valid", {31'd0, out_valid}, 32'd0);

      // Back-to-back push/pop: occupancy must stay at 1, one result per cycle.
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; imm_in = 14'(16'h0100 + i); mode = 2'b00;
         step();
         chk($sformatf("pp%0d_data", i), out_data, 32'h0000_0100 + 32'(i));
         chk($sformatf("pp%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
      end
      in_valid = 1'b0;
      step();
      chk("pp_drain_valid", {31'd0, out_valid}, 32'd0);

      // Backpressure.
      out_ready = 1'b0;
      in_valid = 1'b1; imm_in = 14'h0001; mode = 2'b00;
      step();
      chk("bp_a_in_ready", {31'd0, in_ready}, 32'd1);
      chk("bp_a_data",     out_data, 32'h0000_0001);
      imm_in = 14'h0002;
      step();
      chk("bp_full_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_full_data",     out_data, 32'h0000_0001);
      in_valid = 1'b0;
      step();
      chk("bp_hold_data",  out_data, 32'h0000_0001);
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      out_ready = 1'b1;
      step();
      chk("bp_pop1_data",     out_data, 32'h0000_0002);
      chk("bp_pop1_in_ready", {31'd0, in_ready}, 32'd1);
      step();
      chk("bp_pop2_valid", {31'd0, out_valid}, 32'd0);

      // Flush with full buffer and a same-cycle push attempt.
      out_ready = 1'b0;
      in_valid = 1'b1; imm_in = 14'h0011; step();
      imm_in = 14'h0022; step();
      flush = 1'b1; imm_in = 14'h0033;
      step();
      flush = 1'b0; in_valid = 1'b0;
      chk("fl_full_valid",    {31'd0, out_valid}, 32'd0);
      chk("fl_full_in_ready", {31'd0, in_ready}, 32'd1);

      // Flush at count=1 where the same-cycle push would otherwise be accepted.
      in_valid = 1'b1; imm_in = 14'h0044; step();
      flush = 1'b1; imm_in = 14'h0055;
      step();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      chk("fl_one_valid",    {31'd0, out_valid}, 32'd0);
      chk("fl_one_in_ready", {31'd0, in_ready}, 32'd1);
      step();
      chk("fl_one_stays_empty", {31'd0, out_valid}, 32'd0);

      // Reset mid-stream.
      out_ready = 1'b0;
      in_valid = 1'b1; imm_in = 14'h0066; step();
      imm_in = 14'h0077; step();
      rst = 1'b1; imm_in = 14'h0088;
      step();
      rst = 1'b0; in_valid = 1'b0;
      chk("rs_valid",    {31'd0, out_valid}, 32'd0);
      chk("rs_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rs_data",     out_data, 32'd0);
      chk("rs_neg_cnt",  {16'd0, neg_cnt}, 32'd0);

      // Negative-count accounting.
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; imm_in = 14'h2000 | 14'(i); mode = (i % 2 == 0) ? 2'b01 : 2'b10;
         step();
      end
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; imm_in = 14'h3F00; mode = 2'b00;
         step();
      end
      in_valid = 1'b1; imm_in = 14'h0005; mode = 2'b01;
      step();
      in_valid = 1'b0;
      step();
      chk("cnt_after_pushes", {16'd0, neg_cnt}, CNT_EN ? 32'd5 : 32'd0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("cnt_after_flush", {16'd0, neg_cnt}, CNT_EN ? 32'd5 : 32'd0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("cnt_after_rst", {16'd0, neg_cnt}, 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
